// File: rtl/atmega_pio_pcint_if.sv
// atmega_pio_pcint_if: IO data bus between the core and the PIO port.
interface atmega_pio_pcint_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] addr_i;
    logic          wr_i;
    logic          rd_i;
    logic [DW-1:0] bus_i;
    logic [DW-1:0] bus_o;
    modport master (output addr_i, wr_i, rd_i, bus_i, input bus_o);
    modport slave  (input addr_i, wr_i, rd_i, bus_i, output bus_o);
endinterface

// File: rtl/atmega_pio_pcint.sv
// atmega_pio_pcint: ATmega-style PIO port with toggle/clear/set and pin-change interrupts.
// Optional glitch filter enabled by defining ATMEGA_PIO_PCINT_GLITCH_FILTER_EN.
module atmega_pio_pcint #(
    parameter int                    BUS_ADDR_DATA_LEN    = 8,
    parameter int                    PORT_WIDTH           = 8,
    parameter int                    BASE_ADDR            = 0,
    parameter int                    SYNC_STAGES          = 2,
    parameter logic [PORT_WIDTH-1:0] PINMASK              = 'hFF,
    parameter logic [PORT_WIDTH-1:0] INVERSE_MASK         = 'h0,
    parameter logic [PORT_WIDTH-1:0] INITIAL_OUTPUT_VALUE = 'h00,
    parameter logic [PORT_WIDTH-1:0] INITIAL_DIR_VALUE    = 'h00,
    parameter int                    FILTER_CYCLES        = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    atmega_pio_pcint_if.slave     bus,
    input  logic [PORT_WIDTH-1:0] io_i,
    output logic [PORT_WIDTH-1:0] io_o,
    output logic [PORT_WIDTH-1:0] io_dir_o,
    output logic                  irq_o
);
    localparam int SH = PORT_WIDTH <= 8 ? 0 : PORT_WIDTH <= 16 ? 1 : 2;
    localparam int IW = BUS_ADDR_DATA_LEN - SH;
`ifdef ATMEGA_PIO_PCINT_GLITCH_FILTER_EN
    // Arming must also cover the filter delay, or pads high at reset would flag.
    localparam int ARM = SYNC_STAGES + 1 + FILTER_CYCLES;
`else
    localparam int ARM = SYNC_STAGES + 1;
`endif
    localparam int CW = $clog2(ARM + 1);

    typedef enum logic {ARM_WAIT, RUN} arm_t;

    arm_t                  r_state, w_state_nx;
    logic [CW-1:0]         r_cnt;
    logic [PORT_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [PORT_WIDTH-1:0] r_port, r_ddr, r_pcmsk, r_pcrise, r_pcfall, r_pcifr, r_prev;
    logic [PORT_WIDTH-1:0] w_s, w_filt, w_rise, w_fall, w_set, w_clr, w_port_nx, w_rdata, w_d;
    logic [IW-1:0]         w_idx;
    logic [8:0]            w_we;

    assign w_idx = bus.addr_i[BUS_ADDR_DATA_LEN-1:SH] - IW'(BASE_ADDR);
    assign w_d   = bus.bus_i & PINMASK;

    always_comb begin
        for (int k = 0; k < 9; k++) w_we[k] = bus.wr_i && (w_idx == IW'(k));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= io_i & PINMASK;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef ATMEGA_PIO_PCINT_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_flt
        if (PINMASK[g]) begin : g_on
            logic [FW-1:0] r_fc;
            logic          r_f;
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_fc <= '0;
                    r_f  <= 1'b0;
                end else if (w_s[g] == r_f) begin
                    r_fc <= '0;
                end else if (r_fc == FW'(FILTER_CYCLES - 1)) begin
                    r_fc <= '0;
                    r_f  <= w_s[g];
                end else begin
                    r_fc <= r_fc + 1'b1;
                end
            end
            assign w_filt[g] = r_f;
        end else begin : g_off
            assign w_filt[g] = 1'b0;
        end
    end
`else
    assign w_filt = w_s;
`endif

    assign w_rise = w_filt & ~r_prev;
    assign w_fall = ~w_filt & r_prev;
    assign w_set  = (r_state == RUN) ? PINMASK & ((w_rise & r_pcrise) | (w_fall & r_pcfall)) : '0;
    assign w_clr  = w_we[8] ? bus.bus_i : '0;

    always_comb begin
        w_state_nx = (r_state == ARM_WAIT && r_cnt == CW'(ARM)) ? RUN : r_state;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ARM_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= (r_state == ARM_WAIT && r_cnt != CW'(ARM)) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    assign w_port_nx = w_we[0] ? w_d :
                       w_we[1] ? r_port & ~w_d :
                       w_we[2] ? r_port | w_d :
                       w_we[4] ? r_port ^ w_d : r_port;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_port   <= INITIAL_OUTPUT_VALUE & PINMASK;
            r_ddr    <= INITIAL_DIR_VALUE & PINMASK;
            r_pcmsk  <= '0;
            r_pcrise <= '0;
            r_pcfall <= '0;
            r_pcifr  <= '0;
            r_prev   <= '0;
        end else begin
            r_port   <= w_port_nx;
            r_ddr    <= w_we[3] ? w_d : r_ddr;
            r_pcmsk  <= w_we[5] ? w_d : r_pcmsk;
            r_pcrise <= w_we[6] ? w_d : r_pcrise;
            r_pcfall <= w_we[7] ? w_d : r_pcfall;
            r_pcifr  <= (r_pcifr & ~w_clr) | w_set;
            r_prev   <= w_filt;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            IW'(0):  w_rdata = r_port;
            IW'(3):  w_rdata = r_ddr;
            IW'(4):  w_rdata = (w_filt ^ INVERSE_MASK) & PINMASK;
            IW'(5):  w_rdata = r_pcmsk;
            IW'(6):  w_rdata = r_pcrise;
            IW'(7):  w_rdata = r_pcfall;
            IW'(8):  w_rdata = r_pcifr;
            default: w_rdata = '0;
        endcase
    end

    assign bus.bus_o = bus.rd_i ? w_rdata : '0;
    assign io_dir_o  = r_ddr;
    assign irq_o     = |(r_pcifr & r_pcmsk);

    for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_pad
        assign io_o[g] = r_ddr[g] ? (r_port[g] ^ INVERSE_MASK[g]) : 1'bz;
    end
endmodule

// File: tb/tb_atmega_pio_pcint.sv
// tb_atmega_pio_pcint: directed table plus hand-written timing sequences for the PIO port.
module tb_atmega_pio_pcint;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] io_i = 8'hFF;
    logic [7:0] io_o, io_dir_o;
    logic       irq_o;
    logic [7:0] r;
    int         n_cmp = 0;
    int         n_bad = 0;

    atmega_pio_pcint_if #(.AW(8), .DW(8)) bif ();

    atmega_pio_pcint dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .bus      (bif),
        .io_i     (io_i),
        .io_o     (io_o),
        .io_dir_o (io_dir_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] idx;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tv [17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr_op(input logic [3:0] idx, input logic [7:0] d);
        bif.addr_i = {4'b0, idx};
        bif.bus_i  = d;
        bif.wr_i   = 1'b1;
        @(posedge clk);
        #1 bif.wr_i = 1'b0;
    endtask

    task automatic rd_op(input logic [3:0] idx, output logic [7:0] q);
        bif.addr_i = {4'b0, idx};
        bif.rd_i   = 1'b1;
        #1 q = bif.bus_o;
        bif.rd_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{2'd0, 4'd3, 8'h0F, 8'h00};
        tv[1]  = '{2'd0, 4'd0, 8'h05, 8'h00};
        tv[2]  = '{2'd1, 4'd0, 8'h00, 8'h05};
        tv[3]  = '{2'd0, 4'd4, 8'h03, 8'h00};
        tv[4]  = '{2'd1, 4'd0, 8'h00, 8'h06};
        tv[5]  = '{2'd2, 4'd0, 8'h00, 8'h06};
        tv[6]  = '{2'd3, 4'd0, 8'h00, 8'h0F};
        tv[7]  = '{2'd0, 4'd2, 8'h80, 8'h00};
        tv[8]  = '{2'd1, 4'd0, 8'h00, 8'h86};
        tv[9]  = '{2'd0, 4'd1, 8'h06, 8'h00};
        tv[10] = '{2'd1, 4'd0, 8'h00, 8'h80};
        tv[11] = '{2'd1, 4'd3, 8'h00, 8'h0F};
        tv[12] = '{2'd0, 4'd9, 8'hFF, 8'h00};
        tv[13] = '{2'd1, 4'd9, 8'h00, 8'h00};
        tv[14] = '{2'd1, 4'd0, 8'h00, 8'h80};
        tv[15] = '{2'd1, 4'd4, 8'h00, 8'hFF};
        tv[16] = '{2'd1, 4'd6, 8'h00, 8'hFF};

        bif.addr_i = '0;
        bif.bus_i  = '0;
        bif.wr_i   = 1'b0;
        bif.rd_i   = 1'b0;

        // Reset state
        cycles(3);
        rd_op(4'd3, r);
        check("reset_ddr_read", r, 8'h00);
        check("reset_irq", {7'b0, irq_o}, 8'h00);
        check("reset_dir", io_dir_o, 8'h00);

        // Pads high at reset release must not flag even with rise enabled early
        @(negedge clk);
        rst_i = 1'b1;
        wr_op(4'd6, 8'hFF);
        @(negedge clk);
        wr_op(4'd5, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rd_op(4'd8, r);
            check($sformatf("arm_pcifr_c%0d", i), r, 8'h00);
            check($sformatf("arm_irq_c%0d", i), {7'b0, irq_o}, 8'h00);
        end

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            case (tv[i].kind)
                2'd0: wr_op(tv[i].idx, tv[i].d);
                2'd1: begin
                    rd_op(tv[i].idx, r);
                    check($sformatf("vec%0d_read", i), r, tv[i].exp);
                end
                2'd2: check($sformatf("vec%0d_io_o", i), io_o & io_dir_o, tv[i].exp);
                default: check($sformatf("vec%0d_io_dir", i), io_dir_o, tv[i].exp);
            endcase
        end

        // Rise on pin 0: PIN after 2 edges, flag on the 3rd
        @(negedge clk);
        io_i = 8'h00;
        cycles(5);
        wr_op(4'd6, 8'h01);
        @(negedge clk);
        wr_op(4'd5, 8'h01);
        @(negedge clk);
        rd_op(4'd8, r);
        check("rise_pre_pcifr", r, 8'h00);
        io_i = 8'h01;
        @(negedge clk);
        rd_op(4'd4, r);
        check("rise_pin_e1", r, 8'h00);
        @(negedge clk);
        rd_op(4'd4, r);
        check("rise_pin_e2", r, 8'h01);
        rd_op(4'd8, r);
        check("rise_pcifr_e2", r, 8'h00);
        check("rise_irq_e2", {7'b0, irq_o}, 8'h00);
        @(negedge clk);
        rd_op(4'd8, r);
        check("rise_pcifr_e3", r, 8'h01);
        check("rise_irq_e3", {7'b0, irq_o}, 8'h01);
        @(negedge clk);
        wr_op(4'd8, 8'h01);
        check("clr_irq", {7'b0, irq_o}, 8'h00);

        // Fall on pin 1 with mask off, then unmask
        @(negedge clk);
        io_i = 8'h03;
        cycles(5);
        wr_op(4'd7, 8'h02);
        @(negedge clk);
        wr_op(4'd5, 8'h00);
        @(negedge clk);
        io_i = 8'h01;
        cycles(5);
        rd_op(4'd8, r);
        check("fall_pcifr", r, 8'h02);
        check("fall_irq_masked", {7'b0, irq_o}, 8'h00);
        wr_op(4'd5, 8'h02);
        check("fall_irq_unmasked", {7'b0, irq_o}, 8'h01);
        @(negedge clk);
        wr_op(4'd8, 8'h02);

        // Clear and new rise on the same edge: set wins
        @(negedge clk);
        io_i = 8'h00;
        cycles(5);
        rd_op(4'd8, r);
        check("coll_pre_pcifr", r, 8'h00);
        io_i = 8'h01;
        cycles(2);
        wr_op(4'd8, 8'h01);
        @(negedge clk);
        rd_op(4'd8, r);
        check("coll_set_wins", r, 8'h01);
        wr_op(4'd8, 8'h01);
        @(negedge clk);
        rd_op(4'd8, r);
        check("coll_then_clear", r, 8'h00);

        // Concurrent read and write returns the old value
        @(negedge clk);
        bif.addr_i = 8'd0;
        bif.bus_i  = 8'h55;
        bif.wr_i   = 1'b1;
        bif.rd_i   = 1'b1;
        #1 check("rdwr_old", bif.bus_o, 8'h80);
        @(posedge clk);
        #1 bif.wr_i = 1'b0;
        bif.rd_i = 1'b0;
        @(negedge clk);
        rd_op(4'd0, r);
        check("rdwr_new", r, 8'h55);

        // Asynchronous mid-operation reset
        wr_op(4'd5, 8'h01);
        wr_op(4'd6, 8'h00);
        #2 rst_i = 1'b0;
        #1 check("midrst_dir", io_dir_o, 8'h00);
        check("midrst_irq", {7'b0, irq_o}, 8'h00);
        @(negedge clk);
        io_i = 8'h00;
        rst_i = 1'b1;
        @(negedge clk);
        rd_op(4'd0, r);
        check("midrst_port", r, 8'h00);
        rd_op(4'd5, r);
        check("midrst_pcmsk", r, 8'h00);

`ifdef ATMEGA_PIO_PCINT_GLITCH_FILTER_EN
        cycles(12);
        wr_op(4'd6, 8'h04);
        @(negedge clk);
        io_i = 8'h04;
        cycles(3);
        io_i = 8'h00;
        cycles(10);
        rd_op(4'd4, r);
        check("glitch3_pin", r, 8'h00);
        rd_op(4'd8, r);
        check("glitch3_pcifr", r, 8'h00);
        io_i = 8'h04;
        cycles(5);
        rd_op(4'd4, r);
        check("pulse5_pin_e5", r, 8'h00);
        io_i = 8'h00;
        @(negedge clk);
        rd_op(4'd4, r);
        check("pulse5_pin_e6", r, 8'h04);
        @(negedge clk);
        rd_op(4'd8, r);
        check("pulse5_pcifr", r, 8'h04);
`endif

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
